muldiv_hilo_ctrl: RTL and testbench

Sequencer and HI/LO register owner for the multiply/divide path. Accepts an operation request from the control unit and clears the selected sub-unit (mult or div). It then launches the sub-unit with latched operands, waits for its stop flag, and captures the result into the architectural HI/LO registers. It also services mthi/mtlo writes and provides busy, done and exception status to control.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 18 +
 rtl/muldiv_hilo_ctrl_hilo_regs.sv | 47 ++++
 rtl/muldiv_hilo_ctrl.sv | 146 ++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer and its HI/LO storage.
package muldiv_hilo_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_WRITE  = 3'd4
   } state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int DEF_TIMEOUT = 63;
   localparam int DEF_W       = 32;

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_regs.sv
// Architectural HI/LO storage; a sub-unit result load takes priority over mthi/mtlo.
module hilo_regs
   import muldiv_hilo_ctrl_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         res_we,
   input  logic [W-1:0] res_hi,
   input  logic [W-1:0] res_lo,
   input  logic         mthi_we,
   input  logic         mtlo_we,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] lo_q, lo_d;

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (res_we) begin
         hi_d = res_hi;
         lo_d = res_lo;
      end else begin
         if (mthi_we) hi_d = wr_data;
         if (mtlo_we) lo_d = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multiply/divide sequencer: clears, launches and waits on the selected sub-unit,
// then captures its result into HI/LO; also services mthi/mtlo in IDLE.
module muldiv_hilo_ctrl
   import muldiv_hilo_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int W       = DEF_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         op_start,
   input  logic         op_sel,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         mthi_we,
   input  logic         mtlo_we,
   input  logic [W-1:0] wr_data,
   input  logic         mult_done,
   input  logic [W-1:0] mult_hi,
   input  logic [W-1:0] mult_lo,
   input  logic         div_done,
   input  logic [W-1:0] div_hi,
   input  logic [W-1:0] div_lo,
   output logic         sub_reset,
   output logic         mult_start,
   output logic         div_start,
   output logic [W-1:0] sub_a,
   output logic [W-1:0] sub_b,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         busy,
   output logic         op_done,
   output logic         div_zero,
   output logic         timeout_err
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e        state_q, state_d;
   logic          op_sel_q, op_sel_d;
   logic [W-1:0]  sub_a_q, sub_a_d;
   logic [W-1:0]  sub_b_q, sub_b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          div_zero_q, div_zero_d;
   logic          timeout_err_q, timeout_err_d;
   logic          res_we;
   logic          sel_done;
   logic [W-1:0]  res_hi, res_lo;
   logic          idle;

   assign idle     = (state_q == ST_IDLE);
   assign sel_done = (op_sel_q == OP_DIV) ? div_done : mult_done;
   assign res_hi   = (op_sel_q == OP_DIV) ? div_hi : mult_hi;
   assign res_lo   = (op_sel_q == OP_DIV) ? div_lo : mult_lo;

   always_comb begin
      state_d       = state_q;
      op_sel_d      = op_sel_q;
      sub_a_d       = sub_a_q;
      sub_b_d       = sub_b_q;
      cnt_d         = cnt_q;
      div_zero_d    = div_zero_q;
      timeout_err_d = timeout_err_q;
      res_we        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (op_start) begin
               op_sel_d      = op_sel;
               sub_a_d       = op_a;
               sub_b_d       = op_b;
               div_zero_d    = 1'b0;
               timeout_err_d = 1'b0;
               // A zero divisor never reaches the divider; report and finish at once.
               if (op_sel == OP_DIV && op_b == '0) begin
                  div_zero_d = 1'b1;
                  state_d    = ST_WRITE;
               end else begin
                  state_d = ST_CLR;
               end
            end
         end
         ST_CLR:    state_d = ST_LAUNCH;
         ST_LAUNCH: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (sel_done) begin
               res_we  = 1'b1;
               state_d = ST_WRITE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               timeout_err_d = 1'b1;
               state_d       = ST_WRITE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WRITE:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         op_sel_q      <= OP_MULT;
         sub_a_q       <= '0;
         sub_b_q       <= '0;
         cnt_q         <= '0;
         div_zero_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_sel_q      <= op_sel_d;
         sub_a_q       <= sub_a_d;
         sub_b_q       <= sub_b_d;
         cnt_q         <= cnt_d;
         div_zero_q    <= div_zero_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   hilo_regs #(.W(W)) u_hilo (
      .clk     (clk),
      .reset   (reset),
      .res_we  (res_we),
      .res_hi  (res_hi),
      .res_lo  (res_lo),
      .mthi_we (mthi_we && idle),
      .mtlo_we (mtlo_we && idle),
      .wr_data (wr_data),
      .hi      (hi),
      .lo      (lo)
   );

   assign sub_reset   = reset || (state_q == ST_CLR);
   assign mult_start  = (state_q == ST_LAUNCH) && (op_sel_q == OP_MULT);
   assign div_start   = (state_q == ST_LAUNCH) && (op_sel_q == OP_DIV);
   assign sub_a       = sub_a_q;
   assign sub_b       = sub_b_q;
   assign busy        = !idle;
   assign op_done     = (state_q == ST_WRITE);
   assign div_zero    = div_zero_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl with behavioural mult/div sub-units.
module tb_muldiv_hilo_ctrl;

   localparam int W       = 32;
   localparam int TIMEOUT = 63;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         op_start = 1'b0;
   logic         op_sel = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         mthi_we = 1'b0;
   logic         mtlo_we = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         mult_done, div_done;
   logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
   logic         sub_reset, mult_start, div_start;
   logic [W-1:0] sub_a, sub_b, hi, lo;
   logic         busy, op_done, div_zero, timeout_err;

   int checks = 0;
   int errors = 0;

   logic       hang = 1'b0;
   logic       stale_mult = 1'b0;
   logic [5:0] m_cnt = '0, d_cnt = '0;
   logic       m_run = 1'b0, d_run = 1'b0;
   logic       m_done = 1'b0, d_done = 1'b0;
   logic signed [63:0] prod;

   always #5 clk = ~clk;

   muldiv_hilo_ctrl #(.TIMEOUT(TIMEOUT), .W(W)) dut (
      .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
      .op_a(op_a), .op_b(op_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
      .wr_data(wr_data), .mult_done(mult_done), .mult_hi(mult_hi),
      .mult_lo(mult_lo), .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
      .sub_reset(sub_reset), .mult_start(mult_start), .div_start(div_start),
      .sub_a(sub_a), .sub_b(sub_b), .hi(hi), .lo(lo), .busy(busy),
      .op_done(op_done), .div_zero(div_zero), .timeout_err(timeout_err)
   );

   // Sub-unit models: sticky done raised 34 cycles after the start pulse.
   always @(posedge clk) begin
      if (sub_reset) begin
         m_cnt <= '0; m_run <= 1'b0; m_done <= 1'b0;
      end else if (mult_start) begin
         m_cnt <= '0; m_run <= 1'b1;
      end else if (m_run && !m_done && !hang) begin
         if (m_cnt == 6'd32) m_done <= 1'b1;
         m_cnt <= m_cnt + 6'd1;
      end
   end

   always @(posedge clk) begin
      if (sub_reset) begin
         d_cnt <= '0; d_run <= 1'b0; d_done <= 1'b0;
      end else if (div_start) begin
         d_cnt <= '0; d_run <= 1'b1;
      end else if (d_run && !d_done && !hang) begin
         if (d_cnt == 6'd32) d_done <= 1'b1;
         d_cnt <= d_cnt + 6'd1;
      end
   end

   always_comb begin
      prod = $signed({{32{sub_a[31]}}, sub_a}) * $signed({{32{sub_b[31]}}, sub_b});
      mult_hi = prod[63:32];
      mult_lo = prod[31:0];
      div_hi = '0;
      div_lo = '0;
      if (sub_b != '0) begin
         div_hi = $signed(sub_a) % $signed(sub_b);
         div_lo = $signed(sub_a) / $signed(sub_b);
      end
   end

   assign mult_done = m_done || stale_mult;
   assign div_done  = d_done;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b);
      op_start = 1'b1;
      op_sel   = sel;
      op_a     = a;
      op_b     = b;
      tick();
      op_start = 1'b0;
   endtask

   // Ticks until op_done; lat counts cycles since the accepting edge.
   task automatic waitDone(input string tag, inout int lat);
      while (!op_done && lat < 200) begin
         tick();
         lat++;
      end
      checks++;
      assert (op_done === 1'b1)
      else begin
         errors++;
         $error("[TB] FAIL %s: op_done never seen within budget (waited %0d)", tag, lat);
      end
   endtask

   initial begin
      int lat;

      // Reset state
      #1;
      checkOutput("rst_sub_reset", 64'(sub_reset), 64'd1);
      tick(); tick();
      checkOutput("rst_hi", 64'(hi), 64'd0);
      checkOutput("rst_lo", 64'(lo), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_op_done", 64'(op_done), 64'd0);
      checkOutput("rst_sub_a", 64'(sub_a), 64'd0);
      checkOutput("rst_flags", 64'({div_zero, timeout_err, mult_start, div_start}), 64'd0);
      reset = 1'b0;
      tick();
      checkOutput("idle_sub_reset", 64'(sub_reset), 64'd0);

      // Multiply 7 * -3
      applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD);
      checkOutput("mul_c1_sub_reset", 64'({sub_reset, mult_start, busy}), 64'b101);
      tick();
      checkOutput("mul_c2_start", 64'({sub_reset, mult_start, div_start}), 64'b010);
      checkOutput("mul_sub_ops", {sub_a, sub_b}, {32'd7, 32'hFFFF_FFFD});
      tick();
      checkOutput("mul_c3_start_low", 64'(mult_start), 64'd0);
      lat = 3;
      waitDone("mul_done", lat);
      checkOutput("mul_latency", 64'(lat), 64'd37);
      checkOutput("mul_hi", 64'(hi), 64'hFFFF_FFFF);
      checkOutput("mul_lo", 64'(lo), 64'hFFFF_FFEB);
      tick();
      checkOutput("mul_after", 64'({op_done, busy}), 64'b00);

      // Divide 100 / 7 with a stale mult_done held high
      stale_mult = 1'b1;
      applyStimulus(1'b1, 32'd100, 32'd7);
      tick();
      checkOutput("div_start", 64'({mult_start, div_start}), 64'b01);
      lat = 2;
      waitDone("div_done", lat);
      checkOutput("div_latency", 64'(lat), 64'd37);
      checkOutput("div_hi", 64'(hi), 64'd2);
      checkOutput("div_lo", 64'(lo), 64'd14);
      tick();
      stale_mult = 1'b0;

      // Divide by zero
      applyStimulus(1'b1, 32'd55, 32'd0);
      checkOutput("dz_c1", 64'({op_done, div_zero, sub_reset, div_start, busy}), 64'b11001);
      tick();
      checkOutput("dz_c2", 64'({op_done, busy, div_zero}), 64'b001);
      checkOutput("dz_hilo", {hi, lo}, {32'd2, 32'd14});

      // Next op clears div_zero; mthi while busy is ignored
      applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD);
      checkOutput("dz_cleared", 64'(div_zero), 64'd0);
      tick(); tick(); tick();
      mthi_we = 1'b1;
      wr_data = 32'hDEAD_BEEF;
      tick();
      mthi_we = 1'b0;
      checkOutput("mthi_busy_hi", 64'(hi), 64'd2);
      lat = 5;
      waitDone("mul2_done", lat);
      checkOutput("mul2_hi", 64'(hi), 64'hFFFF_FFFF);
      tick();

      // mthi / mtlo in IDLE
      mthi_we = 1'b1;
      wr_data = 32'hDEAD_BEEF;
      tick();
      mthi_we = 1'b0;
      checkOutput("mthi_idle", {hi, lo}, {32'hDEAD_BEEF, 32'hFFFF_FFEB});
      mthi_we = 1'b1;
      mtlo_we = 1'b1;
      wr_data = 32'h1234_5678;
      tick();
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      checkOutput("mthilo_both", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

      // Timeout
      hang = 1'b1;
      applyStimulus(1'b0, 32'd3, 32'd4);
      tick(); tick();
      lat = 0;
      waitDone("to_done", lat);
      checkOutput("to_cycles", 64'(lat), 64'(TIMEOUT));
      checkOutput("to_err", 64'(timeout_err), 64'd1);
      checkOutput("to_hilo", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
      tick();
      hang = 1'b0;

      // Reset during WAIT
      applyStimulus(1'b1, 32'd100, 32'd7);
      tick(); tick();
      repeat (9) tick();
      reset = 1'b1;
      #1;
      checkOutput("midrst_sub_reset", 64'(sub_reset), 64'd1);
      tick();
      reset = 1'b0;
      checkOutput("midrst_state", 64'({busy, op_done, timeout_err}), 64'b000);
      checkOutput("midrst_hilo", {hi, lo}, 64'd0);
      checkOutput("midrst_sub_a", 64'(sub_a), 64'd0);
      tick();
      checkOutput("midrst_no_done", 64'({op_done, busy}), 64'b00);

      // New op after reset completes normally
      applyStimulus(1'b1, 32'd100, 32'd7);
      lat = 1;
      waitDone("post_rst_done", lat);
      checkOutput("post_rst_hilo", {hi, lo}, {32'd2, 32'd14});
      tick();
      checkOutput("post_rst_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
